// File: rtl/intr_ctrl.sv
// Interrupt pending/priority controller.
// Latches single-cycle event pulses as pending, applies an enable mask,
// selects the lowest-index eligible source and presents it to the core
// through an irq/ack/eoi handshake (one interrupt in flight, no nesting).
// Ports:
//   clk, rst_n     clock, synchronous active-low reset
//   intr_pulse     per-source one-cycle event pulses
//   mask_we        enable-mask write strobe, mask_wdata new mask
//   ovf_clr        write-1-to-clear overflow flags
//   irq_ack        core accepts the presented request
//   irq_eoi        core finished servicing the active interrupt
//   irq, irq_id    request to core and its source index
//   in_service     acknowledged interrupt awaiting eoi
//   intr_mask      current enable mask
//   intr_pending   latched pending events
//   intr_ovf       sticky lost-event flags
module intr_ctrl #(
  parameter int unsigned NUM_SRC = 4,
  parameter int unsigned ID_W    = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_SRC-1:0] intr_pulse,
  input  logic               mask_we,
  input  logic [NUM_SRC-1:0] mask_wdata,
  input  logic [NUM_SRC-1:0] ovf_clr,
  input  logic               irq_ack,
  input  logic               irq_eoi,
  output logic               irq,
  output logic [ID_W-1:0]    irq_id,
  output logic               in_service,
  output logic [NUM_SRC-1:0] intr_mask,
  output logic [NUM_SRC-1:0] intr_pending,
  output logic [NUM_SRC-1:0] intr_ovf
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [ID_W-1:0]    id_nxt;
  logic [ID_W-1:0]    winner;
  logic               winner_vld;
  logic               ack_take;
  logic [NUM_SRC-1:0] eligible;
  logic [NUM_SRC-1:0] clr_vec;
  logic [NUM_SRC-1:0] pend_nxt;
  logic [NUM_SRC-1:0] ovf_nxt;
  logic [NUM_SRC-1:0] mask_nxt;

  // Lowest-index eligible source; scanning downwards lets the lowest index overwrite.
  always_comb begin
    eligible   = intr_pending & intr_mask;
    winner     = '0;
    winner_vld = 1'b0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        winner     = ID_W'(i);
        winner_vld = 1'b1;
      end
    end
  end

  // Next-state logic: the request id is captured on entry to REQ and frozen until IDLE.
  always_comb begin
    state_nxt = state;
    id_nxt    = irq_id;
    ack_take  = 1'b0;
    case (state)
      IDLE: begin
        if (winner_vld) begin
          state_nxt = REQ;
          id_nxt    = winner;
        end
      end
      REQ: begin
        // eoi arriving with ack is ignored: ack takes precedence.
        if (irq_ack) begin
          ack_take  = 1'b1;
          state_nxt = ACTIVE;
        end
      end
      ACTIVE: begin
        if (irq_eoi) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Pending/overflow/mask updates; a new pulse wins over the ack clear.
  always_comb begin
    clr_vec = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (ack_take && (irq_id == ID_W'(i))) begin
        clr_vec[i] = 1'b1;
      end
    end
    pend_nxt = (intr_pending & ~clr_vec) | intr_pulse;
    // A pulse is lost only if the previous event is still pending after this edge.
    ovf_nxt  = (intr_ovf & ~ovf_clr) | (intr_pulse & intr_pending & ~clr_vec);
    mask_nxt = mask_we ? mask_wdata : intr_mask;
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      irq          <= 1'b0;
      irq_id       <= '0;
      in_service   <= 1'b0;
      intr_mask    <= '0;
      intr_pending <= '0;
      intr_ovf     <= '0;
    end else begin
      state        <= state_nxt;
      irq          <= (state_nxt == REQ);
      irq_id       <= id_nxt;
      in_service   <= (state_nxt == ACTIVE);
      intr_mask    <= mask_nxt;
      intr_pending <= pend_nxt;
      intr_ovf     <= ovf_nxt;
    end
  end

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed self-checking bench for intr_ctrl.
module tb_intr_ctrl;

  logic       clk;
  logic       rst_n;
  logic [3:0] intr_pulse;
  logic       mask_we;
  logic [3:0] mask_wdata;
  logic [3:0] ovf_clr;
  logic       irq_ack;
  logic       irq_eoi;
  logic       irq;
  logic [1:0] irq_id;
  logic       in_service;
  logic [3:0] intr_mask;
  logic [3:0] intr_pending;
  logic [3:0] intr_ovf;

  int n_checks = 0;
  int n_errors = 0;

  intr_ctrl #(.NUM_SRC(4), .ID_W(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .intr_pulse   (intr_pulse),
    .mask_we      (mask_we),
    .mask_wdata   (mask_wdata),
    .ovf_clr      (ovf_clr),
    .irq_ack      (irq_ack),
    .irq_eoi      (irq_eoi),
    .irq          (irq),
    .irq_id       (irq_id),
    .in_service   (in_service),
    .intr_mask    (intr_mask),
    .intr_pending (intr_pending),
    .intr_ovf     (intr_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic write_mask(input logic [3:0] m);
    mask_we    = 1'b1;
    mask_wdata = m;
    tick();
    mask_we    = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    intr_pulse = 4'b1111;
    mask_we    = 1'b1;
    mask_wdata = 4'b1111;
    ovf_clr    = 4'b0000;
    irq_ack    = 1'b1;
    irq_eoi    = 1'b0;
    #1;
    tick();
    tick();
    // Reset with all inputs active must leave reset values
    chk("rst_irq",     32'(irq),          32'h0);
    chk("rst_id",      32'(irq_id),       32'h0);
    chk("rst_insvc",   32'(in_service),   32'h0);
    chk("rst_mask",    32'(intr_mask),    32'h0);
    chk("rst_pending", 32'(intr_pending), 32'h0);
    chk("rst_ovf",     32'(intr_ovf),     32'h0);
    rst_n      = 1'b1;
    intr_pulse = 4'b0000;
    mask_we    = 1'b0;
    mask_wdata = 4'b0000;
    irq_ack    = 1'b0;

    // Basic handshake on src1
    write_mask(4'b0010);
    chk("t1_mask", 32'(intr_mask), 32'h2);
    intr_pulse = 4'b0010; tick(); intr_pulse = 4'b0000;
    chk("t1_pend", 32'(intr_pending), 32'h2);
    chk("t1_irq_lat", 32'(irq), 32'h0);
    tick();
    chk("t1_irq", 32'(irq), 32'h1);
    chk("t1_id",  32'(irq_id), 32'h1);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    chk("t1_ack_pend",  32'(intr_pending), 32'h0);
    chk("t1_ack_insvc", 32'(in_service),   32'h1);
    chk("t1_ack_irq",   32'(irq),          32'h0);
    irq_eoi = 1'b1; tick(); irq_eoi = 1'b0;
    chk("t1_eoi_insvc", 32'(in_service), 32'h0);
    tick();
    chk("t1_eoi_irq", 32'(irq), 32'h0);

    // Masked source stays pending, then requested after enable
    write_mask(4'b0000);
    intr_pulse = 4'b0100; tick(); intr_pulse = 4'b0000;
    chk("t2_pend", 32'(intr_pending), 32'h4);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t2_masked_irq", 32'(irq), 32'h0);
    end
    write_mask(4'b0100);
    tick();
    chk("t2_irq", 32'(irq), 32'h1);
    chk("t2_id",  32'(irq_id), 32'h2);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    irq_eoi = 1'b1; tick(); irq_eoi = 1'b0;
    chk("t2_done", 32'(in_service), 32'h0);

    // Priority: src1 before src3, 1-cycle gap between requests
    write_mask(4'b1111);
    intr_pulse = 4'b1010; tick(); intr_pulse = 4'b0000;
    chk("t3_pend", 32'(intr_pending), 32'ha);
    tick();
    chk("t3_id_first", 32'(irq_id), 32'h1);
    chk("t3_irq_first", 32'(irq), 32'h1);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    chk("t3_pend_after_ack", 32'(intr_pending), 32'h8);
    irq_eoi = 1'b1; tick(); irq_eoi = 1'b0;
    chk("t3_gap_irq", 32'(irq), 32'h0);
    tick();
    chk("t3_irq_second", 32'(irq), 32'h1);
    chk("t3_id_second",  32'(irq_id), 32'h3);

    // Request frozen despite higher-priority arrival
    intr_pulse = 4'b0001; tick(); intr_pulse = 4'b0000;
    chk("t4_pend",   32'(intr_pending), 32'h9);
    chk("t4_frozen", 32'(irq_id), 32'h3);
    tick();
    chk("t4_frozen2", 32'(irq_id), 32'h3);
    chk("t4_irq_held", 32'(irq), 32'h1);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    chk("t4_pend_ack", 32'(intr_pending), 32'h1);
    irq_eoi = 1'b1; tick(); irq_eoi = 1'b0;
    tick();
    chk("t4_next_irq", 32'(irq), 32'h1);
    chk("t4_next_id",  32'(irq_id), 32'h0);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    irq_eoi = 1'b1; tick(); irq_eoi = 1'b0;

    // Overflow set, clear, and pulse coinciding with ack
    intr_pulse = 4'b0100; tick();
    chk("t5_ovf_first", 32'(intr_ovf), 32'h0);
    tick(); intr_pulse = 4'b0000;
    chk("t5_ovf", 32'(intr_ovf), 32'h4);
    chk("t5_id",  32'(irq_id),   32'h2);
    ovf_clr = 4'b0100; tick(); ovf_clr = 4'b0000;
    chk("t5_ovf_clr", 32'(intr_ovf), 32'h0);
    irq_ack = 1'b1; intr_pulse = 4'b0100; tick();
    irq_ack = 1'b0; intr_pulse = 4'b0000;
    chk("t5_pend_set_wins", 32'(intr_pending), 32'h4);
    chk("t5_ovf_no_set",    32'(intr_ovf),     32'h0);
    chk("t5_insvc",         32'(in_service),   32'h1);
    irq_eoi = 1'b1; tick(); irq_eoi = 1'b0;
    tick();
    chk("t5_rerequest", 32'(irq_id), 32'h2);
    chk("t5_rereq_irq", 32'(irq),    32'h1);

    // ack and eoi together in REQ: ack taken, eoi ignored
    irq_ack = 1'b1; irq_eoi = 1'b1; tick();
    irq_ack = 1'b0; irq_eoi = 1'b0;
    chk("t6_ack_eoi_insvc", 32'(in_service),   32'h1);
    chk("t6_ack_eoi_pend",  32'(intr_pending), 32'h0);

    // Reset mid-ACTIVE with pulses active
    rst_n = 1'b0; intr_pulse = 4'b1111;
    tick(); tick();
    chk("t7_rst_insvc", 32'(in_service),   32'h0);
    chk("t7_rst_irq",   32'(irq),          32'h0);
    chk("t7_rst_mask",  32'(intr_mask),    32'h0);
    chk("t7_rst_pend",  32'(intr_pending), 32'h0);
    chk("t7_rst_ovf",   32'(intr_ovf),     32'h0);
    rst_n = 1'b1; intr_pulse = 4'b0000;
    tick();
    chk("t7_post_pend", 32'(intr_pending), 32'h0);
    irq_eoi = 1'b1; tick(); irq_eoi = 1'b0;
    chk("t7_eoi_idle_insvc", 32'(in_service), 32'h0);
    chk("t7_eoi_idle_irq",   32'(irq),        32'h0);
    irq_ack = 1'b1; tick(); irq_ack = 1'b0;
    chk("t7_ack_idle_insvc", 32'(in_service), 32'h0);
    chk("t7_ack_idle_irq",   32'(irq),        32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
